// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, picks between mispredict
// recovery, predictor redirect and sequential PC+4, runs the post-mispredict
// flush window and parks the front end in a terminal halt state.
module fetch_ctrl #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_PC     = '0,
   parameter int unsigned     FLUSH_CYCLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            mem_valid,
   input  logic            ib_ready,
   input  logic            bp_valid,
   input  logic            bp_taken,
   input  logic [XLEN-1:0] bp_npc,
   input  logic            ex_mispredict,
   input  logic [XLEN-1:0] ex_target,
   input  logic            halt,
   output logic [XLEN-1:0] fetch_pc,
   output logic            fetch_req,
   output logic            if_valid,
   output logic            squash,
   output logic [1:0]      state,
   output logic [15:0]     bp_redirect_cnt,
   output logic [15:0]     mispredict_cnt
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned PC_W  = XLEN;
   // Instruction words are 4-byte aligned; low two address bits are dropped.
   localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   flush_cnt_q;
   logic [PC_W-1:0]    pc_q;
   logic               squash_q;
   logic [15:0]        bp_cnt_q;
   logic [15:0]        mp_cnt_q;

   logic               fire;
   logic               mp_accept;
   logic               bp_fire;

   // Request is held low while reset is asserted even though state reads RUN.
   assign fetch_req = reset & (state_q == ST_RUN);
   assign fire      = fetch_req & mem_valid & ib_ready;
   assign if_valid  = fire;

   // Mispredicts are dropped once halted; they override any same-cycle fire.
   assign mp_accept = ex_mispredict & (state_q != ST_HALTED);
   assign bp_fire   = fire & bp_valid & bp_taken & ~mp_accept;

   assign fetch_pc        = pc_q;
   assign squash          = squash_q;
   assign state           = state_q;
   assign bp_redirect_cnt = bp_cnt_q;
   assign mispredict_cnt  = mp_cnt_q;

   // Front-end sequencer: PC selection, flush window, halt and event counters.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_RUN;
         flush_cnt_q <= '0;
         pc_q        <= RESET_PC;
         squash_q    <= 1'b0;
         bp_cnt_q    <= '0;
         mp_cnt_q    <= '0;
      end else begin
         squash_q <= mp_accept;
         if (mp_accept) begin
            pc_q        <= ex_target & ALIGN_MASK;
            state_q     <= ST_FLUSH;
            flush_cnt_q <= CNT_W'(FLUSH_CYCLES);
            mp_cnt_q    <= mp_cnt_q + 16'd1;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (bp_fire) begin
                     pc_q     <= bp_npc & ALIGN_MASK;
                     bp_cnt_q <= bp_cnt_q + 16'd1;
                  end else if (fire) begin
                     pc_q <= pc_q + PC_W'(4);
                  end
                  if (halt) begin
                     state_q <= ST_HALTED;
                  end
               end
               ST_FLUSH: begin
                  if (halt) begin
                     state_q     <= ST_HALTED;
                     flush_cnt_q <= '0;
                  end else if (flush_cnt_q <= CNT_W'(1)) begin
                     state_q     <= ST_RUN;
                     flush_cnt_q <= '0;
                  end else begin
                     flush_cnt_q <= flush_cnt_q - CNT_W'(1);
                  end
               end
               ST_HALTED: begin
                  state_q <= ST_HALTED;
               end
               default: begin
                  state_q <= ST_RUN;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// traffic compared against a cycle-indexed behavioural model.
module tb_fetch_ctrl;

   localparam int unsigned FLUSH = 2;
   localparam logic [31:0] RPC   = 32'h100;
   localparam logic [31:0] AMASK = 32'hFFFF_FFFC;

   logic        clock;
   logic        reset;
   logic        mem_valid, ib_ready, bp_valid, bp_taken;
   logic [31:0] bp_npc, ex_target;
   logic        ex_mispredict, halt;
   logic [31:0] fetch_pc;
   logic        fetch_req, if_valid, squash;
   logic [1:0]  state;
   logic [15:0] bp_redirect_cnt, mispredict_cnt;

   int errors = 0;
   int checks = 0;

   // Model: fetch is blocked while cyc < m_block_until; halted is sticky.
   int          cyc = 0;
   int          m_block_until = 0;
   bit          m_halted = 0;
   bit          m_squash = 0;
   logic [31:0] m_pc = RPC;
   logic [15:0] m_bpc = 0;
   logic [15:0] m_mpc = 0;

   fetch_ctrl #(.XLEN(32), .RESET_PC(RPC), .FLUSH_CYCLES(FLUSH)) dut (
      .clock(clock), .reset(reset),
      .mem_valid(mem_valid), .ib_ready(ib_ready),
      .bp_valid(bp_valid), .bp_taken(bp_taken), .bp_npc(bp_npc),
      .ex_mispredict(ex_mispredict), .ex_target(ex_target), .halt(halt),
      .fetch_pc(fetch_pc), .fetch_req(fetch_req), .if_valid(if_valid),
      .squash(squash), .state(state),
      .bp_redirect_cnt(bp_redirect_cnt), .mispredict_cnt(mispredict_cnt)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] m_state();
      if (m_halted) return 2'd2;
      if (cyc < m_block_until) return 2'd1;
      return 2'd0;
   endfunction

   // One clock: drive at negedge, compare, advance model, return after posedge.
   task automatic step(input bit mv, input bit ib, input bit bv, input bit bt,
                       input logic [31:0] npc, input bit mp,
                       input logic [31:0] tgt, input bit h);
      logic [1:0] es;
      bit efire, acc;
      @(negedge clock);
      mem_valid = mv; ib_ready = ib; bp_valid = bv; bp_taken = bt;
      bp_npc = npc; ex_mispredict = mp; ex_target = tgt; halt = h;
      #1;
      es    = m_state();
      efire = (es == 2'd0) && mv && ib;
      acc   = mp && (es != 2'd2);
      chk("fetch_pc", fetch_pc, m_pc);
      chk("state", 32'(state), 32'(es));
      chk("squash", 32'(squash), 32'(m_squash));
      chk("fetch_req", 32'(fetch_req), 32'(es == 2'd0));
      chk("if_valid", 32'(if_valid), 32'(efire));
      chk("bp_cnt", 32'(bp_redirect_cnt), 32'(m_bpc));
      chk("mp_cnt", 32'(mispredict_cnt), 32'(m_mpc));
      m_squash = acc;
      if (acc) begin
         m_pc = tgt & AMASK;
         m_block_until = cyc + int'(FLUSH) + 1;
         m_mpc = m_mpc + 16'd1;
      end else begin
         if (efire) begin
            if (bv && bt) begin
               m_pc  = npc & AMASK;
               m_bpc = m_bpc + 16'd1;
            end else begin
               m_pc = m_pc + 32'd4;
            end
         end
         if (h && es != 2'd2) m_halted = 1;
      end
      cyc++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input bit h);
      step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, h);
   endtask

   // Assert reset mid-cycle, check the immediate reset state, then release.
   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      mem_valid = 0; ib_ready = 0; bp_valid = 0; bp_taken = 0;
      bp_npc = 0; ex_mispredict = 0; ex_target = 0; halt = 0;
      #1;
      chk("rst_pc", fetch_pc, RPC);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_req", 32'(fetch_req), 32'd0);
      chk("rst_squash", 32'(squash), 32'd0);
      chk("rst_bp_cnt", 32'(bp_redirect_cnt), 32'd0);
      chk("rst_mp_cnt", 32'(mispredict_cnt), 32'd0);
      m_pc = RPC; m_halted = 0; m_squash = 0; m_block_until = 0;
      m_bpc = 0; m_mpc = 0;
      @(negedge clock);
      chk("rst_hold_req", 32'(fetch_req), 32'd0);
      reset = 1'b1;
      #1;
      chk("rel_req", 32'(fetch_req), 32'd1);
   endtask

   initial begin
      reset = 1'b0;
      mem_valid = 0; ib_ready = 0; bp_valid = 0; bp_taken = 0;
      bp_npc = 0; ex_mispredict = 0; ex_target = 0; halt = 0;
      repeat (2) @(posedge clock);

      // Sequential fetch from reset
      do_reset();
      idle(0); chk("seq_pc1", fetch_pc, 32'h104);
      idle(0); chk("seq_pc2", fetch_pc, 32'h108);
      idle(0); chk("seq_pc3", fetch_pc, 32'h10C);
      for (int i = 0; i < 61; i++) idle(0);
      chk("seq_pc200", fetch_pc, 32'h200);

      // Predictor redirect: stalled first, then fired
      step(1, 0, 1, 1, 32'h2F3, 0, 32'h0, 0);
      chk("bp_stall_pc", fetch_pc, 32'h200);
      chk("bp_stall_cnt", 32'(bp_redirect_cnt), 32'd0);
      step(1, 1, 1, 1, 32'h2F3, 0, 32'h0, 0);
      chk("bp_pc", fetch_pc, 32'h2F0);
      chk("bp_cnt1", 32'(bp_redirect_cnt), 32'd1);

      // Mispredict overriding a taken predictor fire
      do_reset();
      step(1, 1, 1, 1, 32'h300, 1, 32'h400, 0);
      chk("mp_pc", fetch_pc, 32'h400);
      chk("mp_squash", 32'(squash), 32'd1);
      chk("mp_state", 32'(state), 32'd1);
      chk("mp_cnt1", 32'(mispredict_cnt), 32'd1);
      chk("mp_bp_cnt0", 32'(bp_redirect_cnt), 32'd0);
      idle(0); chk("mp_sq_off", 32'(squash), 32'd0);
      chk("mp_req_off", 32'(fetch_req), 32'd0);
      idle(0); chk("mp_resume", 32'(fetch_req), 32'd1);
      chk("mp_resume_pc", fetch_pc, 32'h400);
      idle(0); chk("mp_fetch_pc", fetch_pc, 32'h404);

      // Back-to-back mispredicts
      do_reset();
      step(1, 1, 0, 0, 32'h0, 1, 32'h500, 0);
      step(1, 1, 0, 0, 32'h0, 1, 32'h600, 0);
      chk("b2b_squash", 32'(squash), 32'd1);
      chk("b2b_pc", fetch_pc, 32'h600);
      chk("b2b_cnt", 32'(mispredict_cnt), 32'd2);
      idle(0); chk("b2b_flush", 32'(state), 32'd1);
      idle(0); chk("b2b_run", 32'(state), 32'd0);
      chk("b2b_resume_pc", fetch_pc, 32'h600);

      // Halt colliding with mispredict, then terminal halt
      step(1, 1, 0, 0, 32'h0, 1, 32'h700, 1);
      chk("hm_state", 32'(state), 32'd1);
      chk("hm_pc", fetch_pc, 32'h700);
      idle(1); chk("halted", 32'(state), 32'd2);
      chk("halted_req", 32'(fetch_req), 32'd0);
      step(1, 1, 0, 0, 32'h0, 1, 32'h900, 1);
      chk("halt_ign_pc", fetch_pc, 32'h700);
      chk("halt_ign_cnt", 32'(mispredict_cnt), 32'd3);
      do_reset();

      // Random traffic against the model
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            do_reset();
         end else begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
                 1'($urandom_range(0, 9) == 0), $urandom(),
                 1'($urandom_range(0, 39) == 0));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
